// File: rtl/btn_conditioner.sv
// Push-button / start-key input conditioner.
// Per channel: 2-flop synchroniser, counter-based debouncer, registered
// rise/fall pulses and a sticky pending flag held until acknowledged.
module btn_conditioner #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned CNT_BITS = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] pend
);

    logic [WIDTH-1:0]    r_s1;
    logic [WIDTH-1:0]    r_s2;
    logic [WIDTH-1:0]    r_level;
    logic [WIDTH-1:0]    r_rise;
    logic [WIDTH-1:0]    r_fall;
    logic [WIDTH-1:0]    r_pend;
    logic [CNT_BITS-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0]    w_level_next;
    logic [WIDTH-1:0]    w_rise_evt;
    logic [WIDTH-1:0]    w_fall_evt;
    logic [WIDTH-1:0]    w_pend_next;
    logic [CNT_BITS-1:0] w_cnt_next [WIDTH];

    // Debounce next-state: level only moves after s2 has differed for a full terminal count.
    always_comb begin
        w_level_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_next[i] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (r_s2[i] != r_level[i]) begin
                if (&r_cnt[i]) begin
                    w_level_next[i] = r_s2[i];
                    w_cnt_next[i]   = '0;
                end else begin
                    w_level_next[i] = r_level[i];
                    w_cnt_next[i]   = r_cnt[i] + CNT_BITS'(1);
                end
            end else begin
                // Any return to the current level restarts the count.
                w_level_next[i] = r_level[i];
                w_cnt_next[i]   = '0;
            end
        end
        w_rise_evt  = w_level_next & ~r_level;
        w_fall_evt  = ~w_level_next & r_level;
        // A new press wins over a simultaneous acknowledge.
        w_pend_next = w_rise_evt | (r_pend & ~ack);
    end

    // State registers; everything clears immediately on reset, aborting any event in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_pend  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1    <= raw;
            r_s2    <= r_s1;
            r_level <= w_level_next;
            r_rise  <= w_rise_evt;
            r_fall  <= w_fall_evt;
            r_pend  <= w_pend_next;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;
    assign pend  = r_pend;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed, table-driven bench for btn_conditioner with a short debounce count.
module tb_btn_conditioner;

    localparam int unsigned W  = 5;
    localparam int unsigned CB = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] raw;
    logic [W-1:0] ack;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] pend;

    int n_checks = 0;
    int n_errors = 0;

    btn_conditioner #(
        .WIDTH    (W),
        .CNT_BITS (CB)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .raw   (raw),
        .ack   (ack),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .pend  (pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] ack;
        int           n;
        logic [W-1:0] lv;
        logic [W-1:0] rs;
        logic [W-1:0] fl;
        logic [W-1:0] pd;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [4*W-1:0] exp);
        logic [4*W-1:0] got;
        got = {level, rise, fall, pend};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got lv/rs/fl/pd=%b_%b_%b_%b want %b_%b_%b_%b", name,
                     got[4*W-1 -: W], got[3*W-1 -: W], got[2*W-1 -: W], got[W-1:0],
                     exp[4*W-1 -: W], exp[3*W-1 -: W], exp[2*W-1 -: W], exp[W-1:0]);
        end
    endtask

    // Advance n edges, leaving time 1 unit after the last one.
    task automatic edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        // raw, ack, edges, expected level, rise, fall, pend
        vecs[0]  = '{5'h01, 5'h00, 9,  5'h00, 5'h00, 5'h00, 5'h00};
        vecs[1]  = '{5'h01, 5'h00, 1,  5'h01, 5'h01, 5'h00, 5'h01};
        vecs[2]  = '{5'h01, 5'h00, 1,  5'h01, 5'h00, 5'h00, 5'h01};
        vecs[3]  = '{5'h00, 5'h00, 9,  5'h01, 5'h00, 5'h00, 5'h01};
        vecs[4]  = '{5'h00, 5'h00, 1,  5'h00, 5'h00, 5'h01, 5'h01};
        vecs[5]  = '{5'h00, 5'h00, 1,  5'h00, 5'h00, 5'h00, 5'h01};
        vecs[6]  = '{5'h00, 5'h01, 1,  5'h00, 5'h00, 5'h00, 5'h00};
        vecs[7]  = '{5'h00, 5'h00, 3,  5'h00, 5'h00, 5'h00, 5'h00};
        vecs[8]  = '{5'h18, 5'h00, 10, 5'h18, 5'h18, 5'h00, 5'h18};
        vecs[9]  = '{5'h18, 5'h00, 1,  5'h18, 5'h00, 5'h00, 5'h18};
        vecs[10] = '{5'h00, 5'h18, 1,  5'h18, 5'h00, 5'h00, 5'h00};
        vecs[11] = '{5'h00, 5'h00, 8,  5'h18, 5'h00, 5'h00, 5'h00};
        vecs[12] = '{5'h00, 5'h00, 1,  5'h00, 5'h00, 5'h18, 5'h00};
        vecs[13] = '{5'h00, 5'h00, 1,  5'h00, 5'h00, 5'h00, 5'h00};

        // Reset held low with all inputs pressed: outputs stay 0.
        reset = 1'b1;
        raw   = '1;
        ack   = '0;
        #2 reset = 1'b0;
        #1 check("reset_async", '0);
        for (int e = 0; e < 12; e++) begin
            edges(1);
            check("reset_hold", '0);
        end
        raw = '0;
        reset = 1'b1;
        for (int e = 0; e < 20; e++) begin
            edges(1);
            check("post_reset_idle", '0);
        end

        // Table: clean press/release on ch0, ack, and simultaneous ch3/ch4.
        for (int v = 0; v < 14; v++) begin
            raw = vecs[v].raw;
            ack = vecs[v].ack;
            edges(vecs[v].n);
            check($sformatf("vec%0d", v), {vecs[v].lv, vecs[v].rs, vecs[v].fl, vecs[v].pd});
        end
        ack = '0;

        // Bounce on ch1: high 5, low 1, then held; rise only 10 edges after the last edge.
        begin
            int n_rise;
            n_rise = 0;
            for (int e = 1; e <= 20; e++) begin
                raw[1] = (e <= 5 || e >= 7);
                edges(1);
                if (rise[1]) n_rise++;
                check($sformatf("bounce_e%0d", e),
                      {3'b000, (e >= 16), 1'b0, 3'b000, (e == 16), 1'b0,
                       5'b00000, 3'b000, (e >= 16), 1'b0});
            end
            n_checks++;
            if (n_rise != 1) begin
                n_errors++;
                $display("FAIL bounce_rise_count: got %0d want 1", n_rise);
            end
        end
        // Release ch1 and clear its pend.
        raw[1] = 1'b0;
        ack[1] = 1'b1;
        edges(11);
        ack = '0;
        edges(1);
        check("ch1_released", '0);

        // Ack handshake on ch2, then ack coinciding with a new rise: set wins.
        raw[2] = 1'b1;
        edges(10);
        check("ch2_press", {5'h04, 5'h04, 5'h00, 5'h04});
        ack[2] = 1'b1;
        edges(1);
        check("ch2_ack", {5'h04, 5'h00, 5'h00, 5'h00});
        ack[2] = 1'b0;
        raw[2] = 1'b0;
        edges(10);
        check("ch2_release", {5'h00, 5'h00, 5'h04, 5'h00});
        edges(1);
        for (int e = 1; e <= 11; e++) begin
            raw[2] = 1'b1;
            ack[2] = (e == 10);
            edges(1);
            check($sformatf("ch2_setwins_e%0d", e),
                  {2'b00, (e >= 10), 2'b00, 2'b00, (e == 10), 2'b00,
                   5'b00000, 2'b00, (e >= 10), 2'b00});
        end
        ack = '0;
        raw[2] = 1'b0;

        // Reset mid-debounce on ch3: press aborted, restarts after release.
        reset = 1'b0;
        edges(1);
        reset = 1'b1;
        raw[3] = 1'b1;
        edges(5);
        check("ch3_debouncing", '0);
        reset = 1'b0;
        edges(1);
        check("ch3_in_reset", '0);
        reset = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            edges(1);
            check($sformatf("ch3_after_reset_e%0d", e),
                  {1'b0, (e >= 10), 3'b000, 1'b0, (e == 10), 3'b000,
                   5'b00000, 1'b0, (e >= 10), 3'b000});
        end

        // Asynchronous clear between edges.
        #2 reset = 1'b0;
        #1 check("async_clear", '0);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-conditioning stage for the board's push-buttons and start key. It sits directly upstream of the system top's start edge detector and the processor's button input port (port09).
- Each channel gets a 2-flop synchroniser, a counter-based debouncer, registered rise/fall pulses, and a sticky "pending" flag.
- The pending flag is held until acknowledged, so a processor running on a slow divided clock cannot miss a press captured on the fast system clock.

Parameters:
- WIDTH, 5, number of independent input channels (start + 4 buttons).
- CNT_BITS, 18, debounce counter width. The input must be stable for 2^CNT_BITS clk cycles (about 5.2 ms at 50 MHz).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- raw  input  WIDTH  asynchronous raw button/switch levels; 1 = pressed.
- ack  input  WIDTH  per-channel acknowledge; clears pend; level-sensitive, sampled on clk.
- level  output  WIDTH  debounced, synchronised level.
- rise  output  WIDTH  one-cycle pulse when level goes 0->1.
- fall  output  WIDTH  one-cycle pulse when level goes 1->0.
- pend  output  WIDTH  sticky press flag: set by a rise event, cleared by ack.

Behaviour:
- Reset (reset=0, asynchronous): s1, s2, level, rise, fall, pend and all counters go to 0 immediately. Outputs hold 0 while reset is low.
- Reset asserted mid-debounce or mid-pulse aborts that event. No pulse is emitted after release.
- Synchroniser, per channel: s1<=raw, s2<=s1. s2 lags raw by 2 edges. Only s2 feeds the logic.
- Debounce counter cnt (CNT_BITS wide), per channel, evaluated on every clk edge:
  - s2==level: cnt<=0.
  - s2!=level and cnt!=all-ones: cnt<=cnt+1.
  - s2!=level and cnt==all-ones: level<=s2, cnt<=0.
- Glitch rejection: any return of s2 to level before terminal count restarts the count from 0. The counter never wraps while counting.
- Latency: raw changes before edge 1 and stays stable. level changes at edge 2+2^CNT_BITS. With CNT_BITS=3, that is edge 10.
- Pulses are registered and computed at the same edge as the level update:
  - rise<=level_next & ~level.
  - fall<=~level_next & level.
  - Each is high exactly one clk cycle. rise and fall are never both high on one channel.
- Pending flag, per channel, priority on the same edge:
  - rise_event (level_next & ~level): pend<=1. Set wins over a simultaneous ack.
  - else ack=1: pend<=0.
  - else hold.
- ack while pend=0: no effect. A second press before ack leaves pend=1 and is not counted separately.
- Channels are fully independent. Simultaneous events on several channels each behave as above in the same cycle.
- Steady held input yields one rise only; the counter stays 0 while s2==level.
- No combinational path from raw or ack to any output. All outputs are registers.

Test Plan (WIDTH=5, CNT_BITS=3):
- Reset: hold reset=0 with raw=5'b11111 -> level=rise=fall=pend=0 throughout. Release reset with raw=0 -> all outputs stay 0 for 20 cycles.
- Clean press: raw[0] 0->1 just before edge 1, held -> level[0]=1 from edge 10. rise[0]=1 only during the cycle after edge 10. pend[0]=1 from edge 10. Other channels stay 0.
- Bounce rejection: raw[1] high for 5 cycles, low for 1 cycle, then high and held -> no rise before the run becomes stable. level[1] rises exactly 2+8 edges after the final 0->1 transition. Exactly one rise pulse.
- Release: after the clean press, raw[0] 1->0 and held -> fall[0] one cycle at edge 10 after the change. pend[0] remains 1. level[0]=0.
- Ack handshake: pend[2]=1, pulse ack[2] for 1 cycle -> pend[2]=0 next edge. Next, assert ack[2] on the same edge as a new rise[2] -> pend[2]=1 (set wins).
- Reset mid-debounce: raw[3] rises, reset pulsed low at edge 6 for 1 cycle, raw[3] kept high -> no rise at edge 10. level[3] rises at 2+8 edges after reset release.
